gate_tt_checker: RTL and testbench
==================================

Name: gate_tt_checker

Overview:
- Synthesizable truth-table sweep-and-check engine for small combinational or switch-level gates, such as the tranif-built OR3.
- Drives every input combination onto a DUT, waits a settle time, and samples the DUT output into a captured truth-table vector.
- Compares the vector against an expected constant and reports pass/fail plus the first failing index.
- Acts as the response/checking end of the gate-test flow, so the gate can be verified on-chip rather than by a printed table.

Parameters:
- N_IN, 3, number of DUT inputs; N_VEC = 2**N_IN vectors (8 at default).
- SETTLE, 5, clock cycles each vector is held before sampling; must be >= 3.
- EXPECT, 8'hFE, expected truth table of width N_VEC; bit i is the expected y for x = i. Default is OR3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a sweep; sampled only in IDLE.
- x  out  N_IN  stimulus vector to the DUT, registered.
- y  in  1  DUT output; asynchronous to clk.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  single-cycle pulse when the sweep completes.
- pass  out  1  tt == EXPECT; valid from done, held until the next start or rst.
- tt  out  N_VEC  captured truth table; bit i = sampled y for x = i.
- fail_valid  out  1  at least one bit mismatched.
- fail_idx  out  N_IN  lowest index i where tt[i] != EXPECT[i]; 0 if none.

Behaviour:
- Reset
  - rst is synchronous and active-high. It overrides everything, including mid-sweep.
  - Next-cycle values: state = IDLE, x = 0, busy = 0, done = 0, pass = 0, tt = 0, fail_valid = 0, fail_idx = 0, synchronizer flops = 0.
- Input synchronizer
  - y passes through a 2-flop synchronizer; y_s is the second flop.
  - Only y_s is used internally.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE
  - busy = 0.
  - When start = 1: idx <= 0, x <= 0, cnt <= SETTLE-1, tt <= 0, pass <= 0, fail_valid <= 0, fail_idx <= 0, go to SETTLE.
- SETTLE
  - busy = 1, x holds idx.
  - If cnt == 0, go to SAMPLE; else cnt <= cnt-1.
- SAMPLE (one cycle)
  - tt[idx] <= y_s.
  - If y_s != EXPECT[idx] and fail_valid == 0: fail_valid <= 1, fail_idx <= idx.
  - If idx == N_VEC-1, go to DONE.
  - Else idx <= idx+1, x <= idx+1, cnt <= SETTLE-1, go to SETTLE.
- DONE (one cycle)
  - done = 1, busy = 0, pass = (tt == EXPECT) using the fully updated tt, then go to IDLE.
- Timing
  - Each vector occupies exactly SETTLE+1 cycles, ascending order 0..N_VEC-1.
  - done is high in cycle N_VEC*(SETTLE+1)+1 after the edge that accepts start; that is cycle 49 at default parameters.
- Result lifetime: pass, tt, fail_valid and fail_idx hold after done until the next accepted start or rst.
- Boundary conditions
  - start while busy or in DONE is ignored; no restart and no extra done.
  - start held high continuously gives back-to-back sweeps, with one IDLE cycle between a done pulse and the next sweep.
  - idx and x never exceed N_VEC-1; no wrap into a second pass.
  - y unknown or high-Z is sampled as-is; no special handling.
- Settle constraint: SETTLE >= 3 guarantees y_s reflects the current x through x-register + DUT + 2 synchronizer flops.

Test Plan:
- Default params, y = x[0]|x[1]|x[2], one-cycle start pulse → x steps 0..7, each value held 6 cycles; done at cycle 49; tt = 8'hFE, pass = 1, fail_valid = 0.
- y = &x (AND3), EXPECT = FE → tt = 8'h80, pass = 0, fail_valid = 1, fail_idx = 1.
- Stuck faults
  - y tied 0 → tt = 8'h00, fail_idx = 1.
  - y tied 1 → tt = 8'hFF, fail_idx = 0.
  - Both: pass = 0.
- Start during sweep: extra start pulses at cycles 10 and 20 → exactly one done at cycle 49; results identical to the first test.
- Reset mid-sweep: rst at cycle 25 → next cycle busy = 0, x = 0, tt = 0, done never pulses; a fresh start then completes a full 49-cycle sweep with correct results.
- Parameter variant: N_IN = 2, SETTLE = 3, EXPECT = 4'h6 with y = x[0]^x[1] → each vector held 4 cycles; done at cycle 17; pass = 1.

Source files
------------

// File: rtl/gate_tt_checker.sv
// Truth-table sweep-and-check engine: walks x through every input combination,
// samples the synchronized gate response per vector, and compares against EXPECT.
module gate_tt_checker #(
    parameter int                  N_IN   = 3,
    parameter int                  SETTLE = 5,
    parameter logic [2**N_IN-1:0]  EXPECT = 8'hFE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        x,
    input  logic                   y,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2**N_IN-1:0]     tt,
    output logic                   fail_valid,
    output logic [N_IN-1:0]        fail_idx
);
    localparam int                N_VEC    = 2**N_IN;
    localparam int                CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]     CNT_INIT = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0]   LAST     = N_IN'(N_VEC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      y_sync;
    logic            y_s;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic            pass_r;

    assign y_s = y_sync[1];
    assign x   = idx;

    always_ff @(posedge clk) begin
        if (rst) y_sync <= '0;
        else     y_sync <= {y_sync[0], y};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = pass_r;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy      = 1'b1;
                state_nxt = (idx == LAST) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                // tt already holds the last sample here, so the verdict is valid with done
                done      = 1'b1;
                pass      = (tt == EXPECT);
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            cnt        <= '0;
            tt         <= '0;
            pass_r     <= 1'b0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    idx        <= '0;
                    cnt        <= CNT_INIT;
                    tt         <= '0;
                    pass_r     <= 1'b0;
                    fail_valid <= 1'b0;
                    fail_idx   <= '0;
                end
                S_SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                S_SAMPLE: begin
                    tt[idx] <= y_s;
                    if ((y_s != EXPECT[idx]) && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_idx   <= idx;
                    end
                    if (idx != LAST) begin
                        idx <= idx + 1'b1;
                        cnt <= CNT_INIT;
                    end
                end
                S_DONE:  pass_r <= (tt == EXPECT);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: gate models feed y from x; expected results are
// queued at start and checked when done pulses.
module tb_gate_tt_checker;
    logic       clk = 1'b0;
    logic       rst, start, y;
    logic [2:0] x, fail_idx;
    logic       busy, done, pass, fail_valid;
    logic [7:0] tt;

    logic       start1, y1, busy1, done1, pass1, fv1;
    logic [1:0] x1, fidx1;
    logic [3:0] tt1;

    logic [1:0] mode;
    int asserts = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] tt;
        logic       pass;
        logic       fv;
        logic [2:0] fidx;
    } vec_t;

    vec_t tbl[4];
    vec_t sb_q[$];

    gate_tt_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .busy(busy), .done(done),
        .pass(pass), .tt(tt), .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    gate_tt_checker #(.N_IN(2), .SETTLE(3), .EXPECT(4'h6)) u_small (
        .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .busy(busy1), .done(done1),
        .pass(pass1), .tt(tt1), .fail_valid(fv1), .fail_idx(fidx1)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            2'd0:    y = |x;
            2'd1:    y = &x;
            2'd2:    y = 1'b0;
            default: y = 1'b1;
        endcase
    end
    assign y1 = x1[0] ^ x1[1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input vec_t e);
        chk("tt", 32'(tt), 32'(e.tt));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("fail_valid", 32'(fail_valid), 32'(e.fv));
        chk("fail_idx", 32'(fail_idx), 32'(e.fidx));
    endtask

    // Cycle c counts clock periods after the edge that accepts start.
    task automatic run_sweep(input vec_t e, input int extra1, input int extra2);
        int dones = 0;
        int done_cyc = -1;
        vec_t got;
        mode = e.mode;
        sb_q.push_back(e);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = (c == extra1) || (c == extra2);
            if (c <= 48) begin
                chk("x_step", 32'(x), 32'((c - 1) / 6));
                chk("busy_sweep", 32'(busy), 32'd1);
            end else begin
                chk("busy_idle", 32'(busy), 32'd0);
            end
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = c;
                    if (sb_q.size() > 0) begin
                        got = sb_q.pop_front();
                        check_result(got);
                    end
                end
            end
        end
        start = 1'b0;
        chk("done_cycle", 32'(done_cyc), 32'd49);
        chk("done_count", 32'(dones), 32'd1);
        chk("tt_held", 32'(tt), 32'(e.tt));
        chk("fv_held", 32'(fail_valid), 32'(e.fv));
        sb_q.delete();
    endtask

    initial begin
        int dones;
        int d1, d2;
        vec_t e;

        tbl[0] = '{mode: 2'd0, tt: 8'hFE, pass: 1'b1, fv: 1'b0, fidx: 3'd0};
        tbl[1] = '{mode: 2'd1, tt: 8'h80, pass: 1'b0, fv: 1'b1, fidx: 3'd1};
        tbl[2] = '{mode: 2'd2, tt: 8'h00, pass: 1'b0, fv: 1'b1, fidx: 3'd1};
        tbl[3] = '{mode: 2'd3, tt: 8'hFF, pass: 1'b0, fv: 1'b1, fidx: 3'd0};

        rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_tt", 32'(tt), 32'd0);
        chk("rst_fv", 32'(fail_valid), 32'd0);
        chk("rst_fidx", 32'(fail_idx), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_sweep(tbl[i], 0, 0);

        // extra starts while busy must be ignored
        run_sweep(tbl[0], 10, 20);

        // reset mid-sweep
        mode = 2'd0;
        dones = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            rst = (c == 25);
            if (c == 24) chk("partial_tt", 32'(tt), 32'h06);
            if (c == 26) begin
                chk("mid_rst_busy", 32'(busy), 32'd0);
                chk("mid_rst_x", 32'(x), 32'd0);
                chk("mid_rst_tt", 32'(tt), 32'd0);
                chk("mid_rst_fv", 32'(fail_valid), 32'd0);
            end
            if (done) dones++;
        end
        rst = 1'b0;
        chk("mid_rst_no_done", 32'(dones), 32'd0);
        run_sweep(tbl[0], 0, 0);

        // start held high: back-to-back sweeps with one idle cycle between
        mode = 2'd1;
        d1 = -1; d2 = -1; dones = 0;
        sb_q.push_back(tbl[1]);
        sb_q.push_back(tbl[1]);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 60) start = 1'b0;
            if (c == 50) chk("b2b_idle_gap", 32'(busy), 32'd0);
            if (c == 51) chk("b2b_restart", 32'(busy), 32'd1);
            if (done) begin
                dones++;
                if (dones == 1) d1 = c;
                if (dones == 2) d2 = c;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_result(e);
                end
            end
        end
        start = 1'b0;
        chk("b2b_done1", 32'(d1), 32'd49);
        chk("b2b_done2", 32'(d2), 32'd99);
        chk("b2b_count", 32'(dones), 32'd2);
        sb_q.delete();

        // small variant: 2 inputs, XOR2, 4 cycles per vector
        d1 = -1;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk) #1 start1 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c <= 16) chk("small_x", 32'(x1), 32'((c - 1) / 4));
            if (done1 && d1 < 0) begin
                d1 = c;
                chk("small_pass", 32'(pass1), 32'd1);
                chk("small_tt", 32'(tt1), 32'h6);
                chk("small_fv", 32'(fv1), 32'd0);
            end
        end
        chk("small_done_cycle", 32'(d1), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
